// File: rtl/gen_count_digitizer_if.sv
// gen_count_digitizer_if
//   Bundles the request/result signals of the binary-to-BCD digitizer.
//   master : producer of requests (generation counter side / testbench)
//            drives start, value; observes busy, done, digits, lz_mask, overflow
//   slave  : the digitizer itself
//   Signals:
//     start    request conversion of value (sampled only when idle)
//     value    N_WIDTH-bit unsigned number to convert
//     busy     conversion in progress
//     done     one-cycle pulse, new result valid
//     digits   packed BCD, digit i at [4i+3:4i], digit 0 = units
//     lz_mask  bit i set when digit i is a leading zero (bit 0 always 0)
//     overflow last value did not fit in DIGITS decimal digits
interface gen_count_digitizer_if #(
  parameter int N_WIDTH = 16,
  parameter int DIGITS  = 4
) ();
  logic                  start;
  logic [N_WIDTH-1:0]    value;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     lz_mask;
  logic                  overflow;

  modport master (
    output start, value,
    input  busy, done, digits, lz_mask, overflow
  );

  modport slave (
    input  start, value,
    output busy, done, digits, lz_mask, overflow
  );
endinterface

// File: rtl/gen_count_digitizer.sv
// divide
//   Combinational unsigned divider.
//   numerator_i   N_WIDTH-bit dividend
//   denominator_i D_WIDTH-bit divisor (D_WIDTH <= N_WIDTH)
//   quotient_o    N_WIDTH-bit quotient
//   remainder_o   D_WIDTH-bit remainder (always < denominator_i)
//
// gen_count_digitizer
//   Converts the binary generation count into packed BCD, one decimal digit
//   per clock, and publishes digits, leading-zero mask and overflow together
//   on completion.
//   clk  system clock, all state on rising edge
//   rst  synchronous, active-high reset
//   bus  slave side of gen_count_digitizer_if (start/value in, results out)

module divide #(
  parameter int N_WIDTH = 16,
  parameter int D_WIDTH = 4
) (
  input  logic [N_WIDTH-1:0] numerator_i,
  input  logic [D_WIDTH-1:0] denominator_i,
  output logic [N_WIDTH-1:0] quotient_o,
  output logic [D_WIDTH-1:0] remainder_o
);
  assign quotient_o  = numerator_i / N_WIDTH'(denominator_i);
  // The remainder is below the divisor, so it always fits in D_WIDTH bits.
  assign remainder_o = D_WIDTH'(numerator_i % N_WIDTH'(denominator_i));
endmodule

module gen_count_digitizer #(
  parameter int N_WIDTH = 16,
  parameter int DIGITS  = 4
) (
  input logic clk,
  input logic rst,
  gen_count_digitizer_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DIGITS - 1);
  // Mask of the value 0: every digit above the units is a leading zero.
  localparam logic [DIGITS-1:0]   LZ_RESET = {{(DIGITS-1){1'b1}}, 1'b0};
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic {IDLE, CONV} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [N_WIDTH-1:0]    work_q;
  logic [IDX_W-1:0]      idx_q;
  logic [4*DIGITS-1:0]   shadow_q;
  logic [4*DIGITS-1:0]   digits_q;
  logic [DIGITS-1:0]     lz_q;
  logic                  ovf_q;

  logic [N_WIDTH-1:0]    quotient;
  logic [3:0]            remainder;
  logic [4*DIGITS-1:0]   shadow_d;
  logic [DIGITS-1:0]     lz_d;
  logic [DIGITS:1]       zero_above;

  divide #(
    .N_WIDTH (N_WIDTH),
    .D_WIDTH (4)
  ) u_divide (
    .numerator_i   (work_q),
    .denominator_i (4'd10),
    .quotient_o    (quotient),
    .remainder_o   (remainder)
  );

  // Shadow with the current remainder dropped into slot idx. On the last
  // step this is the complete digit vector, so commit uses it directly.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
      assign shadow_d[4*gi +: 4] = (idx_q == IDX_W'(gi)) ? remainder
                                                        : shadow_q[4*gi +: 4];
    end
  endgenerate

  // zero_above[i]: digits i..DIGITS-1 of the final vector are all zero.
  assign zero_above[DIGITS] = 1'b1;
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign zero_above[gi] = zero_above[gi+1] & (shadow_d[4*gi +: 4] == 4'd0);
      assign lz_d[gi]       = zero_above[gi];
    end
  endgenerate
  assign lz_d[0] = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      work_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      digits_q <= '0;
      lz_q     <= LZ_RESET;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q   <= bus.value;
            idx_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= CONV;
          end
        end
        CONV: begin
          shadow_q <= shadow_d;
          work_q   <= quotient;
          idx_q    <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            // Anything left in the quotient after the top digit does not fit.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            idx_q   <= '0;
            if (quotient != '0) begin
              ovf_q    <= 1'b1;
              digits_q <= ALL_NINES;
              lz_q     <= '0;
            end else begin
              ovf_q    <= 1'b0;
              digits_q <= shadow_d;
              lz_q     <= lz_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.digits   = digits_q;
  assign bus.lz_mask  = lz_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_gen_count_digitizer.sv
module tb_gen_count_digitizer;
  logic clk;
  logic rst;
  int checks;
  int failures;

  gen_count_digitizer_if #(.N_WIDTH(16), .DIGITS(4)) bus ();

  gen_count_digitizer #(.N_WIDTH(16), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by plain arithmetic, saturating at 9999.
  function automatic logic [15:0] ref_digits(input int v);
    logic [15:0] r;
    int p;
    r = 16'h0;
    if (v >= 10000) return 16'h9999;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Digit i (i >= 1) is a leading zero iff value < 10^i.
  function automatic logic [3:0] ref_lz(input int v);
    logic [3:0] m;
    int p;
    m = 4'b0;
    if (v >= 10000) return 4'b0;
    p = 10;
    for (int i = 1; i < 4; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one conversion and reports what was observed; comparisons are
  // made by the calling test task.
  task automatic do_conv(input logic [15:0] v, output int lat, output int busy_cnt,
                         output logic busy_at_done, output logic [15:0] d,
                         output logic [3:0] lz, output logic ov, output logic done_after);
    bus.value = v;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    busy_at_done = bus.busy;
    d  = bus.digits;
    lz = bus.lz_mask;
    ov = bus.overflow;
    tick();
    done_after = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.value = 16'd1234;
    tick();
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.digits !== 16'h0 ||
        bus.lz_mask !== 4'b1110 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b digits=%h lz=%b ovf=%b, required 0 0 0000 1110 0",
               bus.busy, bus.done, bus.digits, bus.lz_mask, bus.overflow);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins_over_start: busy=%b, required 0", bus.busy);
    end
    $display("reset: busy=%b digits=%h lz=%b", bus.busy, bus.digits, bus.lz_mask);
  endtask

  task automatic test_vectors();
    logic [15:0] vals[$];
    int lat, bc;
    logic bad, dn_after, ov;
    logic [15:0] d;
    logic [3:0] lz;
    vals = '{16'd1234, 16'd0, 16'd7, 16'd305, 16'd9999, 16'd10000, 16'd65535};
    for (int i = 0; i < 10; i++) vals.push_back(16'($urandom_range(0, 12000)));
    for (int i = 0; i < 4; i++) vals.push_back(16'($urandom));
    foreach (vals[i]) begin
      do_conv(vals[i], lat, bc, bad, d, lz, ov, dn_after);
      $display("conv value=%0d digits=%h lz=%b ovf=%b lat=%0d busy_cycles=%0d",
               vals[i], d, lz, ov, lat, bc);
      checks++;
      if (lat != 4 || bc != 4 || bad !== 1'b0) begin
        failures++;
        $display("FAIL timing value=%0d: latency=%0d busy_cycles=%0d busy_at_done=%b, required 4 4 0",
                 vals[i], lat, bc, bad);
      end
      checks++;
      if (d !== ref_digits(int'(vals[i])) || lz !== ref_lz(int'(vals[i])) ||
          ov !== (vals[i] >= 16'd10000)) begin
        failures++;
        $display("FAIL result value=%0d: digits=%h lz=%b ovf=%b, required %h %b %b",
                 vals[i], d, lz, ov, ref_digits(int'(vals[i])), ref_lz(int'(vals[i])),
                 vals[i] >= 16'd10000);
      end
      checks++;
      if (dn_after !== 1'b0) begin
        failures++;
        $display("FAIL done_single_pulse value=%0d: done=%b, required 0", vals[i], dn_after);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [15:0] got;
    dones = 0;
    got = 16'h0;
    bus.value = 16'd1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.value = 16'd2222;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) begin
        dones++;
        got = bus.digits;
      end
      tick();
    end
    $display("ignore_start: dones=%0d digits=%h", dones, got);
    checks++;
    if (dones != 1 || got !== 16'h1111) begin
      failures++;
      $display("FAIL start_ignored_in_conv: dones=%0d digits=%h, required 1 1111", dones, got);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [15:0] v;
    logic exp_done;
    int dones;
    dones = 0;
    bus.start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      bus.value = 16'($urandom_range(0, 10500));
      if (n % 5 == 0) q.push_back(bus.value);
      tick();
      exp_done = (n % 5 == 4);
      checks++;
      if (bus.done !== exp_done) begin
        failures++;
        $display("FAIL back_to_back_done edge=%0d: done=%b, required %b", n, bus.done, exp_done);
      end
      if (bus.done === 1'b1 && q.size() > 0) begin
        dones++;
        v = q.pop_front();
        $display("b2b value=%0d digits=%h lz=%b ovf=%b", v, bus.digits, bus.lz_mask, bus.overflow);
        checks++;
        if (bus.digits !== ref_digits(int'(v)) || bus.lz_mask !== ref_lz(int'(v))) begin
          failures++;
          $display("FAIL back_to_back_result value=%0d: digits=%h lz=%b, required %h %b",
                   v, bus.digits, bus.lz_mask, ref_digits(int'(v)), ref_lz(int'(v)));
        end
      end
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (dones != 6) begin
      failures++;
      $display("FAIL back_to_back_count: dones=%0d, required 6", dones);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, dones;
    logic bad, dn_after, ov;
    logic [15:0] d;
    logic [3:0] lz;
    do_conv(16'd42, lat, bc, bad, d, lz, ov, dn_after);
    checks++;
    if (d !== 16'h0042 || lz !== 4'b1100) begin
      failures++;
      $display("FAIL pre_abort_42: digits=%h lz=%b, required 0042 1100", d, lz);
    end
    bus.value = 16'd8888;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("abort: busy=%b done=%b digits=%h lz=%b ovf=%b",
             bus.busy, bus.done, bus.digits, bus.lz_mask, bus.overflow);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.digits !== 16'h0 ||
        bus.lz_mask !== 4'b1110 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL abort_state: busy=%b done=%b digits=%h lz=%b ovf=%b, required 0 0 0000 1110 0",
               bus.busy, bus.done, bus.digits, bus.lz_mask, bus.overflow);
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done: dones=%0d, required 0", dones);
    end
    do_conv(16'd56, lat, bc, bad, d, lz, ov, dn_after);
    $display("after_abort value=56 digits=%h lz=%b", d, lz);
    checks++;
    if (d !== 16'h0056 || lz !== 4'b1100 || ov !== 1'b0 || lat != 4) begin
      failures++;
      $display("FAIL post_abort_56: digits=%h lz=%b ovf=%b lat=%0d, required 0056 1100 0 4",
               d, lz, ov, lat);
    end
  endtask

  task automatic test_value_change();
    logic [15:0] v, old;
    int n;
    for (int t = 0; t < 4; t++) begin
      old = bus.digits;
      v = 16'($urandom_range(0, 9999));
      bus.value = v;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 20) begin
        checks++;
        if (bus.digits !== old) begin
          failures++;
          $display("FAIL digits_hold_during_conv: digits=%h, required %h", bus.digits, old);
        end
        bus.value = 16'($urandom);
        tick();
        n++;
      end
      $display("value_change sampled=%0d digits=%h lz=%b", v, bus.digits, bus.lz_mask);
      checks++;
      if (n != 4 || bus.digits !== ref_digits(int'(v)) || bus.lz_mask !== ref_lz(int'(v))) begin
        failures++;
        $display("FAIL value_sampled_once value=%0d: digits=%h lz=%b lat=%0d, required %h %b 4",
                 v, bus.digits, bus.lz_mask, n, ref_digits(int'(v)), ref_lz(int'(v)));
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.value = 16'd0;
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_value_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
